seq_divider: RTL and testbench

//  Unsigned sequential restoring divider; the inverse operation of the combinational

---
 rtl/div_pkg.sv | 14 +
 rtl/seq_divider_trial_sub.sv | 37 +++
 rtl/seq_divider.sv | 106 ++++++++++
 tb/tb_seq_divider.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and sizing for the sequential restoring divider.
package div_pkg;

  localparam int DIV_WIDTH = 4;

  typedef enum logic [1:0] {IDLE, RUN, ZERO, DONE} div_state_t;

  function automatic int cnt_bits(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int CNT_W = cnt_bits(DIV_WIDTH);

endpackage

// File: rtl/seq_divider_trial_sub.sv
// Trial subtractor for the divider: a - b as a ripple of full adders
// with b inverted and carry-in 1; neg is the borrow out.
module fullAdd (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module trial_sub #(
  parameter int N = 5
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         neg
);
  logic [N:0] c;

  assign c[0] = 1'b1;

  for (genvar i = 0; i < N; i++) begin : g_bit
    fullAdd u_fa (
      .a   (a[i]),
      .b   (~b[i]),
      .cin (c[i]),
      .s   (diff[i]),
      .cout(c[i+1])
    );
  end

  assign neg = ~c[N];
endmodule

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per clock, start/ready/done handshake.
//   state | meaning
//   IDLE  | ready, waiting for start; operands latched on accept
//   RUN   | one shift/trial-subtract iteration per cycle
//   ZERO  | divisor was 0: load saturated result
//   DONE  | one-cycle done pulse, results valid
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = cnt_bits(WIDTH);

  div_state_t       state, state_nxt;
  logic [WIDTH-1:0] q, r, d;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   rem_t, diff;
  logic             neg, keep;
  logic [WIDTH-1:0] q_nxt, r_nxt;

  assign rem_t = {r, q[WIDTH-1]};

  trial_sub #(.N(WIDTH+1)) u_sub (
    .a   (rem_t),
    .b   ({1'b0, d}),
    .diff(diff),
    .neg (neg)
  );

  // rem_t < 2*d, so borrow and the sign bit of diff always agree
  assign keep  = neg | diff[WIDTH];
  assign q_nxt = {q[WIDTH-2:0], ~keep};
  assign r_nxt = keep ? rem_t[WIDTH-1:0] : diff[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = (divisor == '0) ? ZERO : RUN;
      RUN:  if (cnt == '0) state_nxt = DONE;
      ZERO: state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready = (state == IDLE);
    done  = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q           <= '0;
      r           <= '0;
      d           <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          q           <= dividend;
          r           <= '0;
          d           <= divisor;
          cnt         <= CW'(WIDTH-1);
          quotient    <= '0;
          remainder   <= '0;
          div_by_zero <= 1'b0;
        end
        RUN: begin
          q   <= q_nxt;
          r   <= r_nxt;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            quotient  <= q_nxt;
            remainder <= r_nxt;
          end
        end
        // q still holds the untouched dividend here
        ZERO: begin
          quotient    <= '1;
          remainder   <= q;
          div_by_zero <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: directed cases with literal results, exhaustive
// back-to-back sweep and random traffic, all compared each cycle to a model.
module tb_seq_divider;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         ready, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  seq_divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .ready      (ready),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // model: busy = remaining non-ready cycles; results appear as busy reaches 1
  int           busy = 0;
  logic [W-1:0] ma = '0, mb = '0, mq = '0, mr = '0;
  logic         mz = 1'b0;
  int           m_dones = 0;
  int           d_dones = 0;

  always @(posedge clk) begin
    if (rst) begin
      busy <= 0; mq <= '0; mr <= '0; mz <= 1'b0;
    end else if (busy > 0) begin
      busy <= busy - 1;
      if (busy == 2) begin
        m_dones <= m_dones + 1;
        if (mb == '0) begin
          mq <= '1; mr <= ma; mz <= 1'b1;
        end else begin
          mq <= ma / mb; mr <= ma % mb; mz <= 1'b0;
        end
      end
    end else if (start) begin
      ma <= dividend; mb <= divisor;
      mq <= '0; mr <= '0; mz <= 1'b0;
      busy <= (divisor == '0) ? 2 : W + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      if (done) d_dones <= d_dones + 1;
      chk("ready", 32'(ready), 32'(busy == 0));
      chk("done", 32'(done), 32'(busy == 1));
      chk("quotient", 32'(quotient), 32'(mq));
      chk("remainder", 32'(remainder), 32'(mr));
      chk("div_by_zero", 32'(div_by_zero), 32'(mz));
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    while (!ready && n < 30) begin @(negedge clk); n++; end
    if (n >= 30) chk("issue_timeout", 32'(n), 32'(0));
    dividend = a; divisor = b; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // called just after the accepting edge; lat = edges from accept to the done cycle
  task automatic wait_done(input string tag, input int exp_lat, input logic [W-1:0] eq,
                           input logic [W-1:0] er, input logic ez);
    int n = 0;
    @(negedge clk);
    while (!done && n < 20) begin @(negedge clk); n++; end
    if (exp_lat >= 0) chk({tag, "_latency"}, 32'(n), 32'(exp_lat));
    else if (n >= 20) chk({tag, "_timeout"}, 32'(n), 32'(0));
    chk({tag, "_q"}, 32'(quotient), 32'(eq));
    chk({tag, "_r"}, 32'(remainder), 32'(er));
    chk({tag, "_dbz"}, 32'(div_by_zero), 32'(ez));
  endtask

  initial begin
    int lowc, dpos, n;
    logic [W-1:0] cq, cr;
    logic cz;
    bit seen;

    @(posedge clk); #1 chk_en = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("reset_ready", 32'(ready), 32'(1));
    chk("reset_q", 32'(quotient), 32'(0));

    // 13/3: done in the fifth cycle after accept, ready low for 5 cycles
    issue(4'd13, 4'd3);
    lowc = 0; dpos = -1; cq = '0; cr = '0; cz = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done) begin dpos = k; cq = quotient; cr = remainder; cz = div_by_zero; end
      if (ready) break;
      lowc++;
    end
    chk("t1_done_pos", 32'(dpos), 32'(4));
    chk("t1_ready_low", 32'(lowc), 32'(5));
    chk("t1_q", 32'(cq), 32'(4));
    chk("t1_r", 32'(cr), 32'(1));
    chk("t1_dbz", 32'(cz), 32'(0));

    issue(4'd5, 4'd10);  wait_done("t2a", 4, 4'd0, 4'd5, 1'b0);
    issue(4'd15, 4'd1);  wait_done("t2b", 4, 4'd15, 4'd0, 1'b0);
    issue(4'd9, 4'd0);   wait_done("t3a", 1, 4'd15, 4'd9, 1'b1);
    issue(4'd8, 4'd2);   wait_done("t3b", 4, 4'd4, 4'd0, 1'b0);

    // start pulse during RUN is ignored; start held across done is taken in IDLE
    issue(4'd12, 4'd5);
    @(negedge clk); @(negedge clk);
    dividend = 4'd1; divisor = 4'd1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    dividend = 4'd6; divisor = 4'd3; start = 1'b1;
    wait_done("t4a", -1, 4'd2, 4'd2, 1'b0);
    @(posedge clk);
    @(posedge clk); #1 start = 1'b0;
    wait_done("t4b", 4, 4'd2, 4'd0, 1'b0);

    // reset sampled on the third iteration edge aborts the division
    issue(4'd11, 4'd3);
    @(posedge clk); @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("t5_ready", 32'(ready), 32'(1));
    chk("t5_q", 32'(quotient), 32'(0));
    chk("t5_r", 32'(remainder), 32'(0));
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin @(negedge clk); if (done) seen = 1'b1; end
    chk("t5_no_done", 32'(seen), 32'(0));
    issue(4'd7, 4'd2);   wait_done("t5b", 4, 4'd3, 4'd1, 1'b0);

    // exhaustive back-to-back with start held high
    start = 1'b1;
    for (int i = 0; i < 256; i++) begin
      dividend = 4'(i >> 4); divisor = 4'(i);
      n = 0;
      while (!ready && n < 30) begin @(negedge clk); n++; end
      if (n >= 30) chk("sweep_timeout", 32'(n), 32'(0));
      @(posedge clk); #1;
    end
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;

    // random traffic with occasional resets
    for (int k = 0; k < 3000; k++) begin
      start    = 1'($urandom_range(0, 1));
      dividend = 4'($urandom);
      divisor  = 4'($urandom);
      rst      = ($urandom_range(0, 63) == 0);
      @(posedge clk); #1;
    end
    rst = 1'b0; start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); #1;
    chk("done_count", 32'(d_dones), 32'(m_dones));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
